// File: rtl/perf_counter_dumper.sv
// perf_counter_dumper: snapshots the performance counter bank on a debug
// strobe and streams it as a framed byte sequence over valid/ready.
//
// Frame: SOF, N, then per counter {index, 4 data bytes LSB first}, checksum.
// The checksum is the modulo-256 sum of every byte after SOF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for dump_req; stream idle
// S_SOF   | presenting the start-of-frame marker
// S_COUNT | presenting the counter count N
// S_IDX   | presenting the index byte of counter k
// S_DATA  | presenting data byte b (0..3) of counter k, LSB first
// S_CSUM  | presenting the checksum byte (out_last high)
module perf_counter_dumper #(
  parameter int          NUM_CTRS = 16,
  parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dump_req,
  input  logic [NUM_CTRS*32-1:0]   counters_in,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     dump_done,
  output logic                     req_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_COUNT,
    S_IDX,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [7:0] N_BYTE = 8'(NUM_CTRS);
  localparam logic [7:0] K_LAST = 8'(NUM_CTRS - 1);

  state_t      state_q, state_d;
  logic [31:0] snap_q [NUM_CTRS];
  logic [7:0]  k_q, k_d;
  logic [1:0]  b_q, b_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;

  logic        capture;
  logic        hs;
  logic [31:0] cur_word;
  logic [7:0]  cur_byte;

  // Select the snapshot word for the current counter index.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (k_q == 8'(i)) cur_word = snap_q[i];
    end
  end

  // Pick the data byte within the word, least significant first.
  always_comb begin
    cur_byte = '0;
    case (b_q)
      2'd0:    cur_byte = cur_word[7:0];
      2'd1:    cur_byte = cur_word[15:8];
      2'd2:    cur_byte = cur_word[23:16];
      default: cur_byte = cur_word[31:24];
    endcase
  end

  // Stream outputs depend only on registered state, never on out_ready.
  always_comb begin
    out_valid = 1'b1;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      S_SOF:   out_data = SOF_BYTE;
      S_COUNT: out_data = N_BYTE;
      S_IDX:   out_data = k_q;
      S_DATA:  out_data = cur_byte;
      S_CSUM:  begin
        out_data = csum_q;
        out_last = 1'b1;
      end
      default: out_valid = 1'b0;
    endcase
  end

  assign hs          = out_valid & out_ready;
  assign capture     = (state_q == S_IDLE) & dump_req;
  assign busy        = (state_q != S_IDLE);
  assign dump_done   = done_q;
  assign req_dropped = drop_q;

  // Next-state, counter and checksum update; advances only on handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    b_d     = b_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    drop_d  = drop_q | (dump_req & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_SOF;
          csum_d  = 8'h00;
        end
      end
      S_SOF: begin
        if (hs) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (hs) begin
          state_d = S_IDX;
          k_d     = 8'h00;
          csum_d  = csum_q + out_data;
        end
      end
      S_IDX: begin
        if (hs) begin
          state_d = S_DATA;
          b_d     = 2'd0;
          csum_d  = csum_q + out_data;
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_d = csum_q + out_data;
          b_d    = b_q + 2'd1;
          if (b_q == 2'd3) begin
            if (k_q == K_LAST) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_IDX;
              k_d     = k_q + 8'd1;
            end
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      b_q     <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      b_q     <= b_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Atomic snapshot: all counters load on the single accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTRS; i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CTRS; i++) snap_q[i] <= counters_in[i*32 +: 32];
    end
  end

endmodule

// File: doc/perf_counter_dumper.md
Name: perf_counter_dumper

Overview:
- Reader side of the pipeline performance counter bank.
- On request, takes an atomic snapshot of all counters and serializes it as a framed byte stream over a valid/ready interface.
- The stream feeds the debug UART / testbench log sink, so counters can be read out of silicon or FPGA rather than only written to a file at simulation end.
- Sits beside the performance counter bank in the core top level and is driven by a debug CSR strobe.

Parameters:
- NUM_CTRS, 16, number of 32-bit counters in the snapshot; legal range 1..255.
- SOF_BYTE, 8'hA5, start-of-frame marker byte.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- dump_req  input  1  single-cycle request to snapshot and stream all counters
- counters_in  input  NUM_CTRS*32  flattened live counters; counter k occupies bits [32k+31:32k]
- out_valid  output  1  byte available on out_data
- out_data  output  8  stream byte
- out_last  output  1  high with the final (checksum) byte of a frame
- out_ready  input  1  sink accepts the byte when out_valid and out_ready are both high
- busy  output  1  high from snapshot until the last byte is accepted
- dump_done  output  1  one-cycle pulse, the cycle after the last byte is accepted
- req_dropped  output  1  sticky; set when dump_req arrives while busy; cleared only by rst

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, busy=0, dump_done=0, req_dropped=0.
  - FSM=IDLE; snapshot register cleared to 0.
- Reset mid-frame aborts the frame: out_valid is 0 in the cycle after rst is sampled, and no partial resume occurs.
- Frame format, with N=NUM_CTRS; total bytes = 5N+3 (83 for N=16):
  - byte 0: SOF_BYTE.
  - byte 1: N[7:0].
  - per counter k=0..N-1: index byte k, then 4 data bytes, least significant byte first.
  - final byte: checksum = 8-bit modulo-256 sum of every byte after SOF, i.e. byte 1 through the last data byte.
- FSM states: IDLE, SOF, COUNT, IDX, DATA, CSUM.
  - IDLE: on dump_req, capture all of counters_in into the snapshot register on that clock edge; busy=1 and state=SOF from the next cycle.
  - SOF -> COUNT -> IDX -> DATA: a state advances only on handshake (out_valid & out_ready).
  - DATA: 2-bit byte counter 0..3; after byte 3, go to IDX if k<N-1, else to CSUM.
  - CSUM: out_last=1; on handshake, go to IDLE, busy=0, and pulse dump_done for one cycle.
- Latency: first byte (SOF) is valid one cycle after dump_req is sampled in IDLE. With out_ready held high, one byte transfers per cycle, so the frame completes in 5N+3 consecutive cycles.
- Stream rules:
  - out_valid does not depend combinationally on out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays high.
  - out_valid=0 in IDLE.
- Snapshot is atomic: counters_in changes after the capture edge never affect the frame in flight.
- Checksum accumulator:
  - 8-bit, wraps modulo 256.
  - Cleared when entering SOF.
  - Adds each byte from COUNT through the last DATA byte on its handshake.
- dump_req in IDLE is accepted. dump_req in any other state is ignored and sets req_dropped. This includes the CSUM handshake cycle itself: that request is dropped, not queued.
- dump_req in the same cycle as dump_done (back in IDLE) is accepted normally.
- Counter index byte is the low 8 bits of k; index arithmetic uses 8 bits, since NUM_CTRS is at most 255.

Test Plan:
- N=16, counters_in[k]=32'h0100_0000*k + k, dump_req once, out_ready=1 -> 83 bytes on consecutive cycles:
  - starts A5,10,00,00,00,00,00,01,01,00,00,01 ...
  - out_last only on byte 82, which equals the mod-256 sum of bytes 1..81.
  - dump_done pulses the cycle after, busy falls.
- Same frame with out_ready toggling 1,0,0,1 repeating -> identical 83-byte sequence; out_data stable throughout every stalled cycle.
- Change counters_in every cycle after dump_req -> streamed values equal the values present on the capture edge.
- Second dump_req at byte 40 -> ignored, req_dropped=1 and stays 1; frame unchanged. Another dump_req the cycle after dump_done -> new frame starts.
- Assert rst during byte 20 -> out_valid=0, busy=0, req_dropped=0 next cycle. A subsequent dump_req yields a complete frame starting at A5.
- N=1, counter=32'hFFFF_FFFF -> bytes A5,01,00,FF,FF,FF,FF,FD (checksum 0x01+0xFF*4 = 0x3FD -> 0xFD), out_last on the 8th byte.
